// File: rtl/goal_referee.sv
// goal_referee: frame-synchronous match referee between ball/player physics
// and the hex score display.
//
// Each video frame (a synchronised rising edge of frame_clk) the block tests
// the ball against both goal mouths and keeps both scores in binary. After a
// goal it freezes play for HOLD_FRAMES frames, pulses center_field for one
// frame, then resumes play. When a score reaches WIN_SCORE the match is over
// and play stays frozen until new_match is seen on a frame tick.
//
// Optional build macro: GOAL_REFEREE_OVERTIME_EN adds a sudden_death output
// that rises once both players sit one goal short of WIN_SCORE.
//
// Ports:
//   Clk           in   system clock (50 MHz)
//   Reset         in   asynchronous active-low reset
//   frame_clk     in   vertical sync, asynchronous to Clk
//   BallX/Y/S     in   ball centre x, centre y, radius (10 bits each)
//   new_match     in   level, restarts the match on a frame tick
//   center_field  out  re-centre ball and players
//   freeze        out  force the players' step to zero
//   score1/2      out  player 1 / player 2 goals, binary
//   goal_pulse    out  one-Clk pulse on each counted goal
//   last_scorer   out  0 = player 1, 1 = player 2
//   match_over    out  a player reached WIN_SCORE
//   winner        out  valid while match_over; 0 = player 1, 1 = player 2
//   sudden_death  out  (overtime build only) both players at WIN_SCORE-1
module goal_referee #(
    parameter int GOAL_LEFT_X  = 20,
    parameter int GOAL_RIGHT_X = 619,
    parameter int GOAL_TOP_Y   = 200,
    parameter int GOAL_BOT_Y   = 280,
    parameter int WIN_SCORE    = 5,
    parameter int HOLD_FRAMES  = 60
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [9:0] BallX,
    input  logic [9:0] BallY,
    input  logic [9:0] BallS,
    input  logic       new_match,
    output logic       center_field,
    output logic       freeze,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic       goal_pulse,
    output logic       last_scorer,
    output logic       match_over,
    output logic       winner
`ifdef GOAL_REFEREE_OVERTIME_EN
    ,
    output logic       sudden_death
`endif
);

    localparam logic [10:0] LEFT_X_C  = 11'(GOAL_LEFT_X);
    localparam logic [10:0] RIGHT_X_C = 11'(GOAL_RIGHT_X);
    localparam logic [10:0] TOP_Y_C   = 11'(GOAL_TOP_Y);
    localparam logic [10:0] BOT_Y_C   = 11'(GOAL_BOT_Y);
    localparam logic [3:0]  WIN_C     = 4'(WIN_SCORE);
    localparam logic [7:0]  HOLD_C    = 8'(HOLD_FRAMES - 1);

    typedef enum logic [1:0] {
        KICKOFF = 2'd0,
        PLAY    = 2'd1,
        HOLD    = 2'd2,
        OVER    = 2'd3
    } state_t;

    state_t     state_r;
    logic       fc_meta_r;
    logic       fc_sync_r;
    logic       fc_prev_r;
    logic [7:0] hold_cnt_r;
    logic       center_field_r;
    logic       freeze_r;
    logic [3:0] score1_r;
    logic [3:0] score2_r;
    logic       goal_pulse_r;
    logic       last_scorer_r;
    logic       match_over_r;
    logic       winner_r;
    logic       sudden_death_r;

    logic       tick_s;
    logic       mouth_s;
    logic       left_s;
    logic       right_s;
    logic       goal_s;
    logic       scorer_s;
    logic [3:0] new_score_s;
    logic       tie_s;
    logic       ends_match_s;

    // Saturating score increment; scores never climb past WIN_SCORE.
    function automatic logic [3:0] sat_inc(input logic [3:0] score);
        return (score == WIN_C) ? score : score + 4'd1;
    endfunction

    assign tick_s = fc_sync_r & ~fc_prev_r;

    // Goal geometry, widened to 11 bits so X+S cannot wrap.
    always_comb begin
        mouth_s  = ({1'b0, BallY} >= TOP_Y_C) && ({1'b0, BallY} <= BOT_Y_C);
        left_s   = ({1'b0, BallX} <= (LEFT_X_C + {1'b0, BallS})) && mouth_s;
        right_s  = (({1'b0, BallX} + {1'b0, BallS}) >= RIGHT_X_C) && mouth_s;
        // A ball touching both lines at once is ambiguous and never scores.
        goal_s   = left_s ^ right_s;
        // Left goal means player 2 scored.
        scorer_s = left_s;
        new_score_s = scorer_s ? sat_inc(score2_r) : sat_inc(score1_r);
        tie_s    = (score1_r == (WIN_C - 4'd1)) && (score2_r == (WIN_C - 4'd1));
`ifdef GOAL_REFEREE_OVERTIME_EN
        ends_match_s = (new_score_s == WIN_C) || tie_s;
`else
        ends_match_s = (new_score_s == WIN_C);
`endif
    end

    // Frame-tick synchroniser plus referee FSM with registered outputs.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            fc_meta_r      <= 1'b0;
            fc_sync_r      <= 1'b0;
            fc_prev_r      <= 1'b0;
            state_r        <= KICKOFF;
            hold_cnt_r     <= 8'd0;
            center_field_r <= 1'b1;
            freeze_r       <= 1'b0;
            score1_r       <= 4'd0;
            score2_r       <= 4'd0;
            goal_pulse_r   <= 1'b0;
            last_scorer_r  <= 1'b0;
            match_over_r   <= 1'b0;
            winner_r       <= 1'b0;
            sudden_death_r <= 1'b0;
        end else begin
            fc_meta_r    <= frame_clk;
            fc_sync_r    <= fc_meta_r;
            fc_prev_r    <= fc_sync_r;
            goal_pulse_r <= 1'b0;
            if (tick_s) begin
                if (new_match) begin
                    state_r        <= KICKOFF;
                    hold_cnt_r     <= 8'd0;
                    center_field_r <= 1'b1;
                    freeze_r       <= 1'b0;
                    score1_r       <= 4'd0;
                    score2_r       <= 4'd0;
                    match_over_r   <= 1'b0;
                    winner_r       <= 1'b0;
                    sudden_death_r <= 1'b0;
                end else begin
                    case (state_r)
                        KICKOFF: begin
                            state_r        <= PLAY;
                            center_field_r <= 1'b0;
                            freeze_r       <= 1'b0;
                        end
                        PLAY: begin
                            if (tie_s) begin
                                sudden_death_r <= 1'b1;
                            end
                            if (goal_s) begin
                                if (scorer_s) begin
                                    score2_r <= new_score_s;
                                end else begin
                                    score1_r <= new_score_s;
                                end
                                goal_pulse_r  <= 1'b1;
                                last_scorer_r <= scorer_s;
                                hold_cnt_r    <= HOLD_C;
                                freeze_r      <= 1'b1;
                                if (ends_match_s) begin
                                    state_r      <= OVER;
                                    match_over_r <= 1'b1;
                                    winner_r     <= scorer_s;
                                end else begin
                                    state_r <= HOLD;
                                end
                            end
                        end
                        HOLD: begin
                            // Counter was loaded with HOLD_FRAMES-1, so the
                            // freeze spans exactly HOLD_FRAMES ticks.
                            if (hold_cnt_r == 8'd0) begin
                                state_r        <= KICKOFF;
                                freeze_r       <= 1'b0;
                                center_field_r <= 1'b1;
                            end else begin
                                hold_cnt_r <= hold_cnt_r - 8'd1;
                            end
                        end
                        OVER: begin
                            freeze_r <= 1'b1;
                        end
                        default: begin
                            state_r        <= KICKOFF;
                            center_field_r <= 1'b1;
                            freeze_r       <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign center_field = center_field_r;
    assign freeze       = freeze_r;
    assign score1       = score1_r;
    assign score2       = score2_r;
    assign goal_pulse   = goal_pulse_r;
    assign last_scorer  = last_scorer_r;
    assign match_over   = match_over_r;
    assign winner       = winner_r;
`ifdef GOAL_REFEREE_OVERTIME_EN
    assign sudden_death = sudden_death_r;
`else
    // Flag is only exported in the overtime build.
    logic unused_s;
    assign unused_s = sudden_death_r;
`endif

endmodule

// File: tb/tb_goal_referee.sv
// Scoreboard bench for goal_referee: stimulus pushes expected output
// snapshots and expected goal events into queues; monitors pop and compare.
module tb_goal_referee;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic [9:0] BallX;
    logic [9:0] BallY;
    logic [9:0] BallS;
    logic       new_match;
    logic       center_field;
    logic       freeze;
    logic [3:0] score1;
    logic [3:0] score2;
    logic       goal_pulse;
    logic       last_scorer;
    logic       match_over;
    logic       winner;
`ifdef GOAL_REFEREE_OVERTIME_EN
    logic       sudden_death;
`endif

    goal_referee dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .frame_clk    (frame_clk),
        .BallX        (BallX),
        .BallY        (BallY),
        .BallS        (BallS),
        .new_match    (new_match),
        .center_field (center_field),
        .freeze       (freeze),
        .score1       (score1),
        .score2       (score2),
        .goal_pulse   (goal_pulse),
        .last_scorer  (last_scorer),
        .match_over   (match_over),
        .winner       (winner)
`ifdef GOAL_REFEREE_OVERTIME_EN
        ,
        .sudden_death (sudden_death)
`endif
    );

    typedef struct packed {
        logic       cf;
        logic       fz;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       ls;
        logic       mo;
        logic       w;
    } snap_t;

    typedef struct packed {
        logic [3:0] s1;
        logic [3:0] s2;
        logic       ls;
    } goal_t;

    snap_t exp_q[$];
    string name_q[$];
    goal_t goal_q[$];
    event  sample_ev;

    int total = 0;
    int bad   = 0;

    // Expected-state model kept by the stimulus
    logic [3:0] e_s1 = 4'd0;
    logic [3:0] e_s2 = 4'd0;
    logic       e_ls = 1'b0;

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    // Snapshot monitor: compares all steady outputs on request
    initial begin
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                snap_t e;
                snap_t a;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                a = '{center_field, freeze, score1, score2, last_scorer, match_over, winner};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL %s: got cf=%0b fz=%0b s1=%0d s2=%0d ls=%0b mo=%0b w=%0b, want cf=%0b fz=%0b s1=%0d s2=%0d ls=%0b mo=%0b w=%0b",
                             n, a.cf, a.fz, a.s1, a.s2, a.ls, a.mo, a.w,
                             e.cf, e.fz, e.s1, e.s2, e.ls, e.mo, e.w);
                end
            end
        end
    end

    // Goal monitor: every goal_pulse must match a queued goal and last one cycle
    initial begin
        logic prev_gp;
        prev_gp = 1'b0;
        forever begin
            @(negedge Clk);
            if (prev_gp) begin
                total++;
                if (goal_pulse !== 1'b0) begin
                    bad++;
                    $display("FAIL gp_width: goal_pulse=%0b on second cycle, want 0", goal_pulse);
                end
            end else if (goal_pulse === 1'b1) begin
                total++;
                if (goal_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_goal: got s1=%0d s2=%0d ls=%0b, want no goal",
                             score1, score2, last_scorer);
                end else begin
                    goal_t g;
                    g = goal_q.pop_front();
                    if ({score1, score2, last_scorer} !== g) begin
                        bad++;
                        $display("FAIL goal_event: got s1=%0d s2=%0d ls=%0b, want s1=%0d s2=%0d ls=%0b",
                                 score1, score2, last_scorer, g.s1, g.s2, g.ls);
                    end
                end
            end
            prev_gp = goal_pulse;
        end
    end

    task automatic check(input string n, input logic cf, input logic fz,
                         input logic mo, input logic w);
        exp_q.push_back('{cf, fz, e_s1, e_s2, e_ls, mo, w});
        name_q.push_back(n);
        -> sample_ev;
    endtask

    task automatic set_ball(input int x, input int y, input int s);
        @(negedge Clk);
        BallX = 10'(x);
        BallY = 10'(y);
        BallS = 10'(s);
    endtask

    // One video frame; tick lands three Clk edges after the rising edge
    task automatic frame();
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (5) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (5) @(negedge Clk);
    endtask

    // A counted goal followed by the full hold/kickoff sequence (or OVER)
    task automatic score_goal(input int x, input int y, input int s, input logic who);
        set_ball(x, y, s);
        if (who) e_s2 = e_s2 + 4'd1;
        else     e_s1 = e_s1 + 4'd1;
        e_ls = who;
        goal_q.push_back('{e_s1, e_s2, e_ls});
        frame();
        if (e_s1 == 4'd5 || e_s2 == 4'd5) begin
            check("goal_over", 1'b0, 1'b1, 1'b1, who);
        end else begin
            check("goal_hold", 1'b0, 1'b1, 1'b0, 1'b0);
            // Ball parked in the opposite goal: must be ignored while frozen
            set_ball(616, 240, 4);
            repeat (59) frame();
            check("hold_last_frame", 1'b0, 1'b1, 1'b0, 1'b0);
            set_ball(320, 240, 4);
            frame();
            check("hold_kickoff", 1'b1, 1'b0, 1'b0, 1'b0);
            frame();
            check("resume_play", 1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        Reset     = 1'b0;
        frame_clk = 1'b0;
        new_match = 1'b0;
        BallX     = 10'd320;
        BallY     = 10'd240;
        BallS     = 10'd4;
        #35;
        check("reset_state", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (4) @(negedge Clk);
        check("kickoff_pre_tick", 1'b1, 1'b0, 1'b0, 1'b0);
        frame();
        check("first_play", 1'b0, 1'b0, 1'b0, 1'b0);

        // No frame ticks: state held
        repeat (40) @(negedge Clk);
        check("no_tick_hold", 1'b0, 1'b0, 1'b0, 1'b0);

        // Left goals: nominal, then exact corner of the mouth
        score_goal(22, 240, 4, 1'b1);
        score_goal(24, 280, 4, 1'b1);

        // Near misses and the ambiguous both-goals case
        set_ball(22, 190, 4);  frame(); check("above_mouth", 1'b0, 1'b0, 1'b0, 1'b0);
        set_ball(25, 240, 4);  frame(); check("x_just_out", 1'b0, 1'b0, 1'b0, 1'b0);
        set_ball(22, 281, 4);  frame(); check("below_mouth", 1'b0, 1'b0, 1'b0, 1'b0);
        set_ball(22, 199, 4);  frame(); check("y_just_above", 1'b0, 1'b0, 1'b0, 1'b0);
        set_ball(320, 240, 300); frame(); check("both_goals", 1'b0, 1'b0, 1'b0, 1'b0);
        set_ball(614, 240, 4); frame(); check("right_just_out", 1'b0, 1'b0, 1'b0, 1'b0);

        // Five right goals end the match with player 1 winning
        score_goal(615, 200, 4, 1'b0);
        score_goal(616, 240, 4, 1'b0);
        score_goal(616, 240, 4, 1'b0);
        score_goal(616, 240, 4, 1'b0);
        score_goal(616, 240, 4, 1'b0);

        // OVER ignores further goals
        set_ball(22, 240, 4);
        repeat (3) frame();
        check("over_frozen", 1'b0, 1'b1, 1'b1, 1'b0);

        // New match from OVER
        set_ball(320, 240, 4);
        new_match = 1'b1;
        frame();
        new_match = 1'b0;
        e_s1 = 4'd0;
        e_s2 = 4'd0;
        check("new_match_kickoff", 1'b1, 1'b0, 1'b0, 1'b0);
        frame();
        check("new_match_play", 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset mid-HOLD with the counter at 30
        set_ball(22, 240, 4);
        e_s2 = 4'd1;
        e_ls = 1'b1;
        goal_q.push_back('{e_s1, e_s2, e_ls});
        frame();
        check("goal_before_reset", 1'b0, 1'b1, 1'b0, 1'b0);
        set_ball(320, 240, 4);
        repeat (29) frame();
        check("mid_hold", 1'b0, 1'b1, 1'b0, 1'b0);
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        e_s1 = 4'd0;
        e_s2 = 4'd0;
        e_ls = 1'b0;
        check("async_reset_mid_hold", 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        frame();
        check("play_after_reset", 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (3) @(negedge Clk);
        total++;
        if (goal_q.size() != 0) begin
            bad++;
            $display("FAIL goal_q_drain: %0d goals still pending, want 0", goal_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
